// File: rtl/mem_pkg.sv
// Shared memory-access types: load/store access size and byte-mask helpers.
// Used by the load aligner and its data extractor.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    // Right-aligned byte mask covering one access of the given size.
    function automatic logic [3:0] size_nmask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_nmask = 4'b0001;
            SIZE_HALF: size_nmask = 4'b0011;
            SIZE_WORD: size_nmask = 4'b1111;
            default:   size_nmask = 4'b0000;
        endcase
    endfunction

    // Number of bytes moved by an access of the given size.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_nbytes = 3'd1;
            SIZE_HALF: size_nbytes = 3'd2;
            SIZE_WORD: size_nbytes = 3'd4;
            default:   size_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extractor.sv
// Combinational load data extractor: shifts {hi, lo} right by the byte
// offset, keeps the access bytes and sign/zero-extends to 32 bits.
// Ports: i_hi/i_lo returned words, i_off byte offset, i_size access size,
// i_unsigned zero-extend select, o_data right-aligned result.
module load_extractor
    import mem_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_raw;

    assign w_raw = 32'({i_hi, i_lo} >> {i_off, 3'b000});

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & w_raw[7]}}, w_raw[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_raw[15]}}, w_raw[15:0]};
            SIZE_WORD: o_data = w_raw;
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// Load aligner: turns byte/half/word loads at any byte address into one or
// two word-aligned masked bus reads and returns an extended 32-bit result.
// Ports: clk, rst_n (sync, active low); req_* load request handshake;
// bus_* word read bus (req held until ack); resp_* one-cycle result pulse.
// Build option: LOAD_ALIGNER_MISALIGNED_EN enables word-crossing loads;
// without it those loads answer resp_err with no bus access.
module load_aligner
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        bus_req,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_mask,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_LO = 2'd1,
        S_RD_HI = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_data;
    logic        r_err;

    logic        w_cross_req;
    logic        w_bad_req;
    logic        w_done;
    logic [3:0]  w_nmask;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic [31:0] w_ext;

`ifdef LOAD_ALIGNER_MISALIGNED_EN
    logic [31:0] r_lo;
    logic        r_cross;
`endif

    // Access spills into the next word when off + n exceeds 4 bytes.
    assign w_cross_req = (3'({1'b0, req_addr[1:0]}) + size_nbytes(req_size)) > 3'd4;

`ifdef LOAD_ALIGNER_MISALIGNED_EN
    assign w_bad_req = (req_size == 2'd3);
`else
    assign w_bad_req = (req_size == 2'd3) | w_cross_req;
`endif

    assign w_nmask    = size_nmask(r_size);
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = r_data;
    assign resp_err   = r_err;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_mask  = '0;
        w_done    = 1'b0;
        w_lo      = bus_rdata;
        w_hi      = '0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    w_next = w_bad_req ? S_RESP : S_RD_LO;
                end
            end
            S_RD_LO: begin
                bus_req  = 1'b1;
                bus_addr = r_addr[31:2];
                bus_mask = w_nmask << r_addr[1:0];
                if (bus_ack) begin
`ifdef LOAD_ALIGNER_MISALIGNED_EN
                    if (r_cross) begin
                        w_next = S_RD_HI;
                    end else begin
                        w_next = S_RESP;
                        w_done = 1'b1;
                    end
`else
                    w_next = S_RESP;
                    w_done = 1'b1;
`endif
                end
            end
`ifdef LOAD_ALIGNER_MISALIGNED_EN
            S_RD_HI: begin
                bus_req  = 1'b1;
                bus_addr = r_addr[31:2] + 30'd1;
                bus_mask = w_nmask >> (3'd4 - {1'b0, r_addr[1:0]});
                w_lo     = r_lo;
                w_hi     = bus_rdata;
                if (bus_ack) begin
                    w_next = S_RESP;
                    w_done = 1'b1;
                end
            end
`endif
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The final read word feeds the extractor directly so the result is
    // registered on the same edge that completes the last read.
    load_extractor u_extract (
        .i_hi      (w_hi),
        .i_lo      (w_lo),
        .i_off     (r_addr[1:0]),
        .i_size    (r_size),
        .i_unsigned(r_unsigned),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_data     <= '0;
            r_err      <= 1'b0;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
            r_lo       <= '0;
            r_cross    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
                r_cross    <= w_cross_req;
`endif
                if (w_bad_req) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (w_done) begin
                r_data <= w_ext;
                r_err  <= 1'b0;
            end
`ifdef LOAD_ALIGNER_MISALIGNED_EN
            if (r_state == S_RD_LO && bus_ack) begin
                r_lo <= bus_rdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_load_aligner.sv
// Self-checking bench for load_aligner: directed cases plus random loads,
// checked by a scoreboard against a byte-level memory model.
module tb_load_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic [3:0]  bus_mask;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    load_aligner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_mask    (bus_mask),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  mask;
    } rd_t;

    resp_t       exp_q[$];
    rd_t         rd_q[$];
    int          wait_plan[$];
    logic [31:0] mem[logic [29:0]];
    int          last_resp_cyc = -1;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = mem.exists(ba[31:2]) ? mem[ba[31:2]] : 32'h0;
        return w[8*ba[1:0] +: 8];
    endfunction

    // Reference model: gather n bytes from memory byte by byte, extend,
    // and list which words/lanes the bus must read.
    task automatic issue(input logic [31:0] a, input logic [1:0] sz,
                         input logic u, output int t_acc);
        int          n;
        int          guard;
        resp_t       r;
        rd_t         rd0;
        rd_t         rd1;
        logic [31:0] ba;
        t_acc = -1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
            return;
        end
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        r.err = (sz == 2'd3);
`ifndef LOAD_ALIGNER_MISALIGNED_EN
        if (int'(a[1:0]) + n > 4) r.err = 1'b1;
`endif
        r.data    = '0;
        rd0.waddr = a[31:2];
        rd0.mask  = '0;
        rd1.waddr = a[31:2] + 30'd1;
        rd1.mask  = '0;
        if (!r.err) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 32'(i);
                if (!mem.exists(ba[31:2])) mem[ba[31:2]] = $urandom();
                r.data[8*i +: 8] = mem_byte(ba);
                if (ba[31:2] == rd0.waddr) rd0.mask[ba[1:0]] = 1'b1;
                else rd1.mask[ba[1:0]] = 1'b1;
            end
            if (!u && n < 4 && r.data[8*n-1])
                for (int i = 8 * n; i < 32; i++) r.data[i] = 1'b1;
            rd_q.push_back(rd0);
            if (rd1.mask != 4'b0) rd_q.push_back(rd1);
        end
        exp_q.push_back(r);
        req_valid    = 1'b1;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = u;
        @(posedge clk);
        @(negedge clk);
        t_acc     = cyc;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d resp / %0d reads pending expected 0",
                     exp_q.size(), rd_q.size());
            exp_q.delete();
            rd_q.delete();
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                last_resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 data %h expected none",
                             resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                end
            end
        end
    end

    // Bus responder: wait states from the plan or random, checks address
    // and mask at the ack, and throws spurious acks while the bus is idle.
    initial begin
        int  wl;
        bit  in_rd;
        rd_t e;
        wl    = 0;
        in_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus_ack = 1'b0;
                in_rd   = 1'b0;
            end else begin
                if (bus_ack) begin
                    bus_ack = 1'b0;
                    in_rd   = 1'b0;
                end
                if (bus_req === 1'b1) begin
                    if (!in_rd) begin
                        in_rd = 1'b1;
                        wl = (wait_plan.size() > 0) ? wait_plan.pop_front()
                                                    : int'($urandom_range(0, 2));
                    end
                    if (wl == 0) begin
                        if (rd_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_bus_req: got addr %h mask %b expected none",
                                     bus_addr, bus_mask);
                        end else begin
                            e = rd_q.pop_front();
                            check("bus_addr", {2'b0, bus_addr}, {2'b0, e.waddr});
                            check("bus_mask", {28'b0, bus_mask}, {28'b0, e.mask});
                        end
                        bus_ack   = 1'b1;
                        bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'hDEADBEEF;
                    end else begin
                        wl--;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = $urandom();
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [31:0] a;
        logic [1:0]  sz;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
        check("rst_bus_mask", {28'b0, bus_mask}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        mem[30'h40] = 32'h80112233;
        wait_plan.push_back(0);
        issue(32'h103, 2'd0, 1'b0, t);
        drain();
        check("byte_s_data", resp_data, 32'hFFFFFF80);
        check("byte_s_lat", 32'(last_resp_cyc - t), 32'd1);

        mem[30'h40] = 32'hBEEF1234;
        wait_plan.push_back(0);
        issue(32'h102, 2'd1, 1'b1, t);
        drain();
        check("half_u_data", resp_data, 32'h0000BEEF);
        check("half_u_lat", 32'(last_resp_cyc - t), 32'd1);

        mem[30'h7F] = 32'hAABBCCDD;
        mem[30'h80] = 32'h00112233;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
        wait_plan.push_back(0);
        wait_plan.push_back(2);
        issue(32'h1FF, 2'd2, 1'b0, t);
        drain();
        check("word_cross_data", resp_data, 32'h112233AA);
        check("word_cross_lat", 32'(last_resp_cyc - t), 32'd4);
`else
        issue(32'h1FF, 2'd2, 1'b0, t);
        drain();
        check("word_cross_err", {31'b0, resp_err}, 32'd1);
        check("word_cross_lat", 32'(last_resp_cyc - t), 32'd0);
`endif

        issue(32'h1234, 2'd3, 1'b0, t);
        drain();
        check("size3_err", {31'b0, resp_err}, 32'd1);
        check("size3_data", resp_data, 32'd0);
        check("size3_lat", 32'(last_resp_cyc - t), 32'd0);

        mem[30'h3FFFFFFF] = 32'h55667788;
        mem[30'h0]        = 32'h11223344;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
        wait_plan.push_back(0);
        wait_plan.push_back(0);
        issue(32'hFFFFFFFE, 2'd2, 1'b1, t);
        drain();
        check("wrap_data", resp_data, 32'h33445566);
        check("wrap_lat", 32'(last_resp_cyc - t), 32'd2);
`else
        issue(32'hFFFFFFFE, 2'd2, 1'b1, t);
        drain();
        check("wrap_err", {31'b0, resp_err}, 32'd1);
`endif

        wait_plan.push_back(8);
        issue(32'h200, 2'd2, 1'b0, t);
        repeat (2) @(negedge clk);
        check("mid_bus_req", {31'b0, bus_req}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        rd_q.delete();
        @(negedge clk);
        check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 250; k++) begin
            a = $urandom();
            if ($urandom_range(0, 5) == 0) a[31:4] = '1;
            if ($urandom_range(0, 5) == 0) a[31:4] = '0;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(a, sz, 1'($urandom_range(0, 1)), t);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_aligner.md
# load_aligner

Read-side counterpart of the store data shifter: accepts byte/half/word load requests at arbitrary byte addresses from the core, issues one or two word-aligned reads with byte-enable masks on the memory bus, then shifts, masks and sign/zero-extends the returned bytes into a right-aligned 32-bit result. Sits between the core's load/store stage and the data bus, alongside the store path.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; everything is registered on its rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- bus_req  out  1  word read request, held until acknowledged
- bus_addr  out  30  word address (byte address bits [31:2])
- bus_mask  out  4  byte enables for the read
- bus_ack  in  1  read completes; bus_rdata valid this cycle
- bus_rdata  in  32  read data, little-endian byte lanes
- resp_valid  out  1  one-cycle pulse; result valid
- resp_data  out  32  extended load result
- resp_err  out  1  valid only with resp_valid; request was rejected

## Operation
- off = req_addr[1:0]; n = 1, 2 or 4 bytes; nmask = 4'b0001, 4'b0011 or 4'b1111.
- States: IDLE, RD_LO, RD_HI, RESP.
- IDLE: req_ready = 1. On req_valid, latch addr, size and unsigned.
  - If size = 3, go to RESP with err = 1.
  - If off + n > 4 and the misaligned feature is off, go to RESP with err = 1.
  - Otherwise go to RD_LO.
- RD_LO: bus_req = 1, bus_addr = addr[31:2], bus_mask = (nmask << off) & 4'hF.
  - On bus_ack, capture lo = bus_rdata.
  - Go to RD_HI if the access crosses a word boundary, else go to RESP.
- RD_HI: bus_req = 1, bus_addr = addr[31:2] + 1 (wraps modulo 2^30), bus_mask = nmask >> (4 - off).
  - On bus_ack, capture hi = bus_rdata and go to RESP.
- RESP: resp_valid = 1 for exactly one cycle.
  - Data: raw = {hi, lo} >> (8*off), keep the low n bytes, then extend from bit 8n-1 per req_unsigned.
  - Word loads ignore req_unsigned.
  - On err: resp_data = 0, no bus traffic. Return to IDLE.
- No response back-pressure; the consumer always accepts resp_valid.
- bus_addr and bus_mask stay stable while bus_req is high and not yet acknowledged.
- hi is don't-care (treat as 0) for non-crossing accesses.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - bus_req, resp_valid, resp_err = 0; resp_data = 0; bus_addr = 0; bus_mask = 0.
  - req_ready forced to 0 while rst_n is low.
- Reset mid-transaction abandons the access: no response, bus_req drops on the next cycle.
- Request accepted at edge T:
  - bus_req is high from T+1.
  - Zero-wait ack at T+1 gives resp_valid at T+2 (aligned).
  - A crossing access gets the second ack at T+2 at the earliest and resp_valid at T+3.
- Error responses: resp_valid at T+1.
- Wait states: each cycle bus_ack is low extends the current read by one cycle.
- bus_ack outside RD_LO/RD_HI is ignored.
- req_ready = 0 in RD_LO, RD_HI and RESP. The next request can be accepted the cycle after resp_valid.
- resp_data and resp_err are registered and hold their value until the next response.

## Configuration
- LOAD_ALIGNER_MISALIGNED_EN
  - Defined: word-crossing half/word loads are split into RD_LO + RD_HI as above.
  - Undefined: such requests return resp_err = 1 with no bus access, and the RD_HI state and hi register are not built.
- In-word unaligned loads (e.g. half at off = 1) are always supported.

## Structure
- Shared package mem_pkg holds:
  - typedef enum logic [1:0] access_size_t (SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2)
  - a function returning nmask for a size
- The FSM state enum stays local to the block.
- Sub-module load_extractor (combinational): inputs {hi, lo}, off, size, unsigned; output resp_data. Verified standalone.

## Test plan
- Byte load, addr 0x103, unsigned = 0, bus_rdata 0x80_11_22_33 → bus_mask 4'b1000; resp_data 0xFFFFFF80 at T+2.
- Half load, addr 0x102, unsigned = 1, rdata 0xBEEF_1234 → bus_mask 4'b1100; resp_data 0x0000BEEF.
- Word load, addr 0x1FF, rdata 0xAABBCCDD then 0x00112233, with 2 wait states on the second read:
  - With macro: bus_addr 0x7F then 0x80, masks 4'b1000 / 4'b0111; resp_data 0x112233AA.
  - Without macro: resp_err = 1 at T+1, no bus_req.
- Size = 3 → resp_err = 1, resp_data = 0, no bus traffic. Also addr 0xFFFFFFFE word load (macro on): second bus_addr wraps to 0.
- Assert rst_n low while in RD_LO waiting for ack → no resp_valid; bus_req = 0 and req_ready = 0 during reset; req_ready = 1 the cycle after rst_n releases.
